// File: rtl/ay38500_cfg_pkg.sv
// Shared types and constants for the AY-3-8500 game configuration sequencer.
// Holds the sequencer state encoding, the packed cfg_t pin layout, field indices,
// game selection codes and a helper that turns a game code into a one-hot select.
package ay38500_cfg_pkg;

    // SOFT_WAIT is only entered when the soft-apply build option is enabled.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_VS   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SOFT_WAIT = 3'd4
    } state_t;

    // Bit layout matches the chip pin bundle: {game[2:0], autoserve, size, angle, speed}.
    typedef struct packed {
        logic [2:0] game;
        logic       autoserve;
        logic       size;
        logic       angle;
        logic       speed;
    } cfg_t;

    localparam int CFG_W         = 7;
    localparam int CFG_GAME_HI   = 6;
    localparam int CFG_GAME_LO   = 4;
    localparam int CFG_AUTOSERVE = 3;
    localparam int CFG_SIZE      = 2;
    localparam int CFG_ANGLE     = 1;
    localparam int CFG_SPEED     = 0;

    localparam logic [2:0] GAME_TENNIS   = 3'd0;
    localparam logic [2:0] GAME_SOCCER   = 3'd1;
    localparam logic [2:0] GAME_HANDICAP = 3'd2;
    localparam logic [2:0] GAME_SQUASH   = 3'd3;
    localparam logic [2:0] GAME_PRACTICE = 3'd4;

    function automatic logic [7:0] game_to_onehot(input logic [2:0] game);
        return 8'b0000_0001 << game;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vertical sync rising-edge detector producing a one-cycle frame_tick.
// Ports: clk_sys/reset (async active-high), vs in, frame_tick out (combinational
// from vs and the registered previous vs, so it is high in the cycle vs first reads 1).
module frame_tick_gen (
    input  logic clk_sys,
    input  logic reset,
    input  logic vs,
    output logic frame_tick
);

    logic r_vs_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_vs_d <= 1'b0;
        end else begin
            r_vs_d <= vs;
        end
    end

    // History clears to 0 so a vs already high at reset release counts as an edge.
    assign frame_tick = vs & ~r_vs_d;

endmodule

// File: rtl/game_config_seq.sv
// Applies a requested game configuration to the AY-3-8500 only at frame boundaries,
// wrapping every change in a chip reset of RESET_FRAMES frames plus SETTLE_FRAMES of settling.
// Ports: clk_sys, reset (async active-high), vs, cfg_in[6:0], reset_req in;
//        cfg_out[6:0], game_onehot[7:0], chip_rst_n, busy out (all registered or state decodes).
// Build option: GAME_CONFIG_SEQ_SOFT_APPLY_EN lets changes confined to cfg bits [3:0]
// be applied on the next frame without pulsing the chip reset.
import ay38500_cfg_pkg::*;

module game_config_seq #(
    parameter int RESET_FRAMES  = 4,   // legal 1..15
    parameter int SETTLE_FRAMES = 2    // legal 1..15
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                vs,
    input  logic [CFG_W-1:0]    cfg_in,
    input  logic                reset_req,
    output logic [CFG_W-1:0]    cfg_out,
    output logic [7:0]          game_onehot,
    output logic                chip_rst_n,
    output logic                busy
);

    localparam logic [3:0] RESET_LOAD  = 4'(RESET_FRAMES - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_FRAMES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    cfg_t       r_cfg;
    logic [7:0] r_onehot;
    logic       r_rst_n;

    logic       w_frame_tick;
    logic       w_cfg_diff;
    logic       w_soft_ok;

    frame_tick_gen u_frame_tick_gen (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .vs         (vs),
        .frame_tick (w_frame_tick)
    );

    assign w_cfg_diff = (cfg_in != r_cfg);

`ifdef GAME_CONFIG_SEQ_SOFT_APPLY_EN
    logic w_game_diff;
    assign w_game_diff = (cfg_in[CFG_GAME_HI:CFG_GAME_LO] != r_cfg.game);
    // Same game and no user reset: the chip tolerates the pin change without a reset.
    assign w_soft_ok   = ~w_game_diff & ~reset_req;
`else
    assign w_soft_ok   = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state  <= ST_HOLD;
            r_cnt    <= RESET_LOAD;
            r_rst_n  <= 1'b0;
            r_cfg    <= '{game: GAME_TENNIS, default: 1'b0};
            r_onehot <= 8'h01;
        end else begin
            // Follows cfg_out one cycle later; cfg_out only moves on a frame tick.
            r_onehot <= game_to_onehot(r_cfg.game);

            case (r_state)
                ST_IDLE: begin
                    if (reset_req || w_cfg_diff) begin
                        r_state <= w_soft_ok ? ST_SOFT_WAIT : ST_WAIT_VS;
                    end
                end

                ST_WAIT_VS: begin
                    if (w_frame_tick) begin
                        r_state <= ST_HOLD;
                        r_rst_n <= 1'b0;
                        r_cfg   <= cfg_in;
                        r_cnt   <= RESET_LOAD;
                    end
                end

                ST_HOLD: begin
                    if (w_frame_tick) begin
                        // Keep tracking the request while held so the last value wins.
                        r_cfg <= cfg_in;
                        if (r_cnt == 4'd0 && !reset_req) begin
                            r_state <= ST_SETTLE;
                            r_rst_n <= 1'b1;
                            r_cnt   <= SETTLE_LOAD;
                        end else if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end

                ST_SETTLE: begin
                    // A new request restarts the whole sequence rather than queueing.
                    if (reset_req || w_cfg_diff) begin
                        r_state <= ST_WAIT_VS;
                    end else if (w_frame_tick) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end

`ifdef GAME_CONFIG_SEQ_SOFT_APPLY_EN
                ST_SOFT_WAIT: begin
                    if (!w_soft_ok) begin
                        r_state <= ST_WAIT_VS;
                    end else if (w_frame_tick) begin
                        r_cfg   <= cfg_in;
                        r_state <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_out     = r_cfg;
    assign game_onehot = r_onehot;
    assign chip_rst_n  = r_rst_n;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_game_config_seq.sv
// Directed bench for game_config_seq: stimulus queues expected outputs per frame tick
// and per mid-frame probe; an independent monitor pops and compares them.
// Tick expectations are checked one and a half cycles after the tick edge.
module tb_game_config_seq;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       vs;
    logic [6:0] cfg_in;
    logic       reset_req;
    logic [6:0] cfg_out;
    logic [7:0] game_onehot;
    logic       chip_rst_n;
    logic       busy;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       bsy;
        logic [6:0] cfg;
    } exp_t;

    exp_t tick_q[$];
    exp_t probe_q[$];
    int   applied     = 0;
    int   miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    game_config_seq #(
        .RESET_FRAMES  (4),
        .SETTLE_FRAMES (2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .vs          (vs),
        .cfg_in      (cfg_in),
        .reset_req   (reset_req),
        .cfg_out     (cfg_out),
        .game_onehot (game_onehot),
        .chip_rst_n  (chip_rst_n),
        .busy        (busy)
    );

    task automatic compare(input exp_t e);
        logic [7:0] oh;
        oh = 8'b0000_0001 << e.cfg[6:4];
        applied++;
        if (chip_rst_n !== e.rst_n || busy !== e.bsy || cfg_out !== e.cfg || game_onehot !== oh) begin
            miscompares++;
            $display("FAIL %s: got rst_n=%b busy=%b cfg_out=%h onehot=%h, want rst_n=%b busy=%b cfg_out=%h onehot=%h",
                     e.name, chip_rst_n, busy, cfg_out, game_onehot, e.rst_n, e.bsy, e.cfg, oh);
        end
    endtask

    // Monitor: mirrors the edge detect on the bench side to know when a tick happened.
    initial begin
        logic vs_q;
        int   pend;
        exp_t e;
        vs_q = 1'b0;
        pend = 0;
        forever begin
            @(posedge clk_sys);
            if (reset) begin
                vs_q = 1'b0;
                pend = 0;
            end else begin
                if (pend > 0) pend--;
                if (vs && !vs_q) pend = 2;
                vs_q = vs;
            end
            @(negedge clk_sys);
            if (probe_q.size() > 0) begin
                e = probe_q.pop_front();
                compare(e);
            end
            if (pend == 1) begin
                if (tick_q.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL unexpected_tick: got a frame tick, want no tick");
                end else begin
                    e = tick_q.pop_front();
                    compare(e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic frame(input string name, input logic rn, input logic bz, input logic [6:0] c);
        exp_t e;
        e.name = name; e.rst_n = rn; e.bsy = bz; e.cfg = c;
        tick_q.push_back(e);
        vs = 1'b1;
        step(2);
        vs = 1'b0;
        step(6);
    endtask

    task automatic frames(input string name, input int n, input logic rn, input logic bz, input logic [6:0] c);
        for (int i = 0; i < n; i++) frame(name, rn, bz, c);
    endtask

    task automatic probe(input string name, input logic rn, input logic bz, input logic [6:0] c);
        exp_t e;
        e.name = name; e.rst_n = rn; e.bsy = bz; e.cfg = c;
        probe_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus, want completion before 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        vs        = 1'b0;
        cfg_in    = 7'h00;
        reset_req = 1'b0;
        step(3);
        probe("reset_state", 1'b0, 1'b1, 7'h00);
        step(2);
        reset = 1'b0;
        step(2);

        // Power-up sequence: 4 held frames, 2 settle frames.
        frames("pwr_hold", 3, 1'b0, 1'b1, 7'h00);
        frame ("pwr_release", 1'b1, 1'b1, 7'h00);
        frame ("pwr_settle", 1'b1, 1'b1, 7'h00);
        frame ("pwr_idle", 1'b1, 1'b0, 7'h00);

        // Game 0 -> 3 mid-frame: reset falls only at the next tick.
        step(1);
        cfg_in = 7'h30;
        step(2);
        probe("game3_wait_vs", 1'b1, 1'b1, 7'h00);
        frames("game3_hold", 4, 1'b0, 1'b1, 7'h30);
        frame ("game3_release", 1'b1, 1'b1, 7'h30);
        frame ("game3_settle", 1'b1, 1'b1, 7'h30);
        frame ("game3_idle", 1'b1, 1'b0, 7'h30);

        // Requests changing during HOLD: the last one before release wins.
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        frame("chg_hold0", 1'b0, 1'b1, 7'h30);
        cfg_in = 7'h31;
        frame("chg_hold1", 1'b0, 1'b1, 7'h31);
        cfg_in = 7'h41;
        frames("chg_hold2", 2, 1'b0, 1'b1, 7'h41);
        frame ("chg_release", 1'b1, 1'b1, 7'h41);
        frame ("chg_settle", 1'b1, 1'b1, 7'h41);
        frame ("chg_idle", 1'b1, 1'b0, 7'h41);

        // User reset held for 10 frames stretches the hold.
        reset_req = 1'b1;
        step(1);
        frames("ureq_hold", 10, 1'b0, 1'b1, 7'h41);
        reset_req = 1'b0;
        step(1);
        frame ("ureq_release", 1'b1, 1'b1, 7'h41);
        frame ("ureq_settle", 1'b1, 1'b1, 7'h41);
        frame ("ureq_idle", 1'b1, 1'b0, 7'h41);

        // Changes during SETTLE restart the sequence, including on a tick cycle.
        cfg_in = 7'h21;
        step(1);
        frames("stl_hold_a", 4, 1'b0, 1'b1, 7'h21);
        frame ("stl_release_a", 1'b1, 1'b1, 7'h21);
        step(1);
        cfg_in = 7'h22;
        step(2);
        probe("stl_abandon", 1'b1, 1'b1, 7'h21);
        frames("stl_hold_b", 4, 1'b0, 1'b1, 7'h22);
        frame ("stl_release_b", 1'b1, 1'b1, 7'h22);
        cfg_in = 7'h23;
        frame ("stl_tick_chg", 1'b1, 1'b1, 7'h22);
        frames("stl_hold_c", 4, 1'b0, 1'b1, 7'h23);
        frame ("stl_release_c", 1'b1, 1'b1, 7'h23);
        frame ("stl_settle_c", 1'b1, 1'b1, 7'h23);
        frame ("stl_idle_c", 1'b1, 1'b0, 7'h23);

        // Speed bit only.
        cfg_in = 7'h22;
        step(2);
`ifdef GAME_CONFIG_SEQ_SOFT_APPLY_EN
        probe("soft_wait", 1'b1, 1'b1, 7'h23);
        frame("soft_apply", 1'b1, 1'b0, 7'h22);
`else
        probe("speed_wait_vs", 1'b1, 1'b1, 7'h23);
        frames("speed_hold", 4, 1'b0, 1'b1, 7'h22);
        frame ("speed_release", 1'b1, 1'b1, 7'h22);
        frame ("speed_settle", 1'b1, 1'b1, 7'h22);
        frame ("speed_idle", 1'b1, 1'b0, 7'h22);
`endif

        // Async reset in the middle of HOLD abandons it and restarts a full hold.
        cfg_in = 7'h43;
        step(1);
        frame("mid_hold", 1'b0, 1'b1, 7'h43);
        reset = 1'b1;
        probe("mid_reset", 1'b0, 1'b1, 7'h00);
        step(2);
        reset = 1'b0;
        step(1);
        frames("mid_hold_again", 3, 1'b0, 1'b1, 7'h43);
        frame ("mid_release", 1'b1, 1'b1, 7'h43);
        frame ("mid_settle", 1'b1, 1'b1, 7'h43);
        frame ("mid_idle", 1'b1, 1'b0, 7'h43);

        step(4);
        applied++;
        if (tick_q.size() != 0 || probe_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d ticks and %0d probes still pending, want 0 and 0",
                     tick_q.size(), probe_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/game_config_seq.md
GAME_CONFIG_SEQ -- requirements
Module: game_config_seq

Interface
REQ-001 SHALL have parameter RESET_FRAMES, default 4: number of vsync frames the chip reset is held; legal range 1..15.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 2: number of vsync frames after reset release before a new change is accepted; legal range 1..15.
REQ-003 SHALL have port clk_sys, input, 1: the single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port vs, input, 1: active-high vertical sync from the chip, synchronous to clk_sys.
REQ-006 SHALL have port cfg_in, input, 7: requested config {game[2:0], autoserve, size, angle, speed}.
REQ-007 SHALL have port reset_req, input, 1: level user reset request (OSD reset OR button).
REQ-008 SHALL have port cfg_out, output, 7: applied config driving the chip pins, same field layout as cfg_in.
REQ-009 SHALL have port game_onehot, output, 8: registered value of 1 << cfg_out[6:4].
REQ-010 SHALL have port chip_rst_n, output, 1: active-low chip reset.
REQ-011 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 SHALL derive frame_tick as a one-cycle pulse on each vs rising edge (registered previous vs; first edge after reset detected normally).
REQ-013 SHALL implement states IDLE, WAIT_VS, HOLD and SETTLE.
REQ-014 IDLE: if reset_req=1 or cfg_in!=cfg_out, SHALL go to WAIT_VS next cycle; otherwise SHALL remain in IDLE.
REQ-015 WAIT_VS: on frame_tick SHALL go to HOLD, drive chip_rst_n=0, load cfg_out<=cfg_in, and load frame counter<=RESET_FRAMES-1.
REQ-016 HOLD: on each frame_tick SHALL reload cfg_out<=cfg_in; the last value before release wins.
REQ-017 HOLD: on frame_tick with counter=0 and reset_req=0, SHALL go to SETTLE, set chip_rst_n=1, and load counter<=SETTLE_FRAMES-1; otherwise SHALL decrement the counter, saturating at 0.
REQ-018 HOLD: while reset_req=1, SHALL not exit; reset is held for the longer of reset_req and RESET_FRAMES.
REQ-019 SETTLE: on frame_tick with counter=0 SHALL go to IDLE; otherwise SHALL decrement the counter on frame_tick.
REQ-020 SETTLE: a cfg_in change or reset_req=1 SHALL go to WAIT_VS next cycle, abandoning the settle count.
REQ-021 Any state other than HOLD: reset_req rising SHALL reach WAIT_VS within one cycle; chip_rst_n SHALL fall on the next frame_tick.
REQ-022 A cfg_in change coincident with frame_tick in WAIT_VS or HOLD SHALL be captured by that tick.
REQ-023 cfg_out and game_onehot SHALL change only on frame_tick, so they are never updated mid-frame.
REQ-024 game_onehot SHALL update one cycle after cfg_out.
REQ-025 chip_rst_n SHALL be registered and glitch-free.

Reset
REQ-026 On reset: state=HOLD, counter=RESET_FRAMES-1, chip_rst_n=0, cfg_out=7'h00, game_onehot=8'h01, busy=1, vs history=0.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence; after deassertion, behaviour SHALL be as in REQ-016..REQ-017.

Configuration
REQ-028 With GAME_CONFIG_SEQ_SOFT_APPLY_EN defined: an IDLE-state change confined to cfg bits [3:0] with reset_req=0 SHALL load cfg_out on the next frame_tick and return to IDLE with chip_rst_n held at 1.
REQ-029 Under that macro, a change in game[2:0] or reset_req=1 SHALL still take the full reset path.
REQ-030 Without the macro, every change SHALL take the full reset path of REQ-015..REQ-019.

Structure
REQ-031 Package ay38500_cfg_pkg SHALL hold the state enum, cfg_t packed struct (game, autoserve, size, angle, speed), field-index constants, and GAME_TENNIS..GAME_PRACTICE codes 0..4.
REQ-032 Sub-module frame_tick_gen SHALL implement the vs rising-edge detector of REQ-012; all other logic SHALL be in game_config_seq.

Verification
REQ-033 Reset release, cfg_in=7'h00, 6 vs pulses -> chip_rst_n rises at the 4th tick; busy falls at the 6th tick; game_onehot=8'h01.
REQ-034 From IDLE, cfg_in game 0->3 mid-frame -> chip_rst_n falls at the next tick, not before; cfg_out=7'h30 at that tick; release after 4 ticks; game_onehot=8'h08.
REQ-035 reset_req held for 10 frames -> chip_rst_n stays low 10 frames and releases on the first tick after reset_req=0.
REQ-036 During HOLD, cfg_in changes 0x30->0x31->0x41 across ticks -> cfg_out=0x41 at release.
REQ-037 Speed bit toggled in IDLE -> with macro: cfg_out updates at next tick, chip_rst_n never low; without macro: full 4-frame reset.
REQ-038 cfg_in changed during SETTLE, including on the same cycle as frame_tick -> WAIT_VS next cycle; new HOLD restarts with counter=3.
